// File: rtl/jk_bank_writer.sv
// jk_bank_writer: walks a JK flip-flop bank bit by bit, issuing one
// addressed J/K command per mismatched bit and verifying it a cycle later.
module jk_bank_writer #(
    parameter int W = 8,
    parameter int USE_TOGGLE = 0,
    localparam int SW = (W > 1) ? $clog2(W) : 1,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_target,
    input  logic [W-1:0]  q_fb,
    output logic          jk_en,
    output logic [SW-1:0] jk_sel,
    output logic          J,
    output logic          K,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cmd_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] idx;
    logic [SW-1:0] idx_nxt;
    logic [W-1:0]  tgt;
    logic [W-1:0]  tgt_nxt;
    logic          err_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          mism;
    logic          last;

    assign mism = q_fb[idx] != tgt[idx];
    assign last = idx == SW'(W - 1);

    // State and walk registers; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            tgt       <= '0;
            err       <= 1'b0;
            cmd_count <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            tgt       <= tgt_nxt;
            err       <= err_nxt;
            cmd_count <= cnt_nxt;
        end
    end

    // Next-state logic: accept, scan, verify, finish.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tgt_nxt   = tgt;
        err_nxt   = err;
        cnt_nxt   = cmd_count;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    tgt_nxt   = in_target;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (mism) begin
                    cnt_nxt   = cmd_count + CW'(1);
                    state_nxt = CHECK;
                end else if (last) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + SW'(1);
                end
            end
            CHECK: begin
                if (mism) begin
                    err_nxt = 1'b1;
                end
                if (last) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + SW'(1);
                    state_nxt = SCAN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command and status decode; all command lines are zero unless strobed.
    always_comb begin
        in_ready = state == IDLE;
        done     = state == DONE;
        jk_en    = (state == SCAN) && mism;
        jk_sel   = '0;
        J        = 1'b0;
        K        = 1'b0;
        if (jk_en) begin
            jk_sel = idx;
            if (USE_TOGGLE != 0) begin
                J = 1'b1;
                K = 1'b1;
            end else begin
                J = tgt[idx];
                K = ~tgt[idx];
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_writer.sv
// tb_jk_bank_writer: directed test of jk_bank_writer in set/reset and
// toggle modes against a behavioural JK bank.
module tb_jk_bank_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic [7:0] in_target [2];
    logic [7:0] bank      [2];
    logic       in_ready  [2];
    logic       jk_en     [2];
    logic [2:0] jk_sel    [2];
    logic       J         [2];
    logic       K         [2];
    logic       done      [2];
    logic       err       [2];
    logic [3:0] cmd_count [2];
    logic       load      [2];
    logic [7:0] load_val  [2];
    logic [7:0] stuck0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_bank_writer #(.W(8), .USE_TOGGLE(0)) u_sr (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_target(in_target[0]), .q_fb(bank[0]),
        .jk_en(jk_en[0]), .jk_sel(jk_sel[0]), .J(J[0]), .K(K[0]),
        .done(done[0]), .err(err[0]), .cmd_count(cmd_count[0])
    );

    jk_bank_writer #(.W(8), .USE_TOGGLE(1)) u_tg (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_target(in_target[1]), .q_fb(bank[1]),
        .jk_en(jk_en[1]), .jk_sel(jk_sel[1]), .J(J[1]), .K(K[1]),
        .done(done[1]), .err(err[1]), .cmd_count(cmd_count[1])
    );

    // Behavioural JK bank; instance 0 can have bits stuck at 0.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic [7:0] nb;
            nb = bank[u];
            if (load[u]) begin
                nb = load_val[u];
            end else if (jk_en[u]) begin
                case ({J[u], K[u]})
                    2'b10:   nb[jk_sel[u]] = 1'b1;
                    2'b01:   nb[jk_sel[u]] = 1'b0;
                    2'b11:   nb[jk_sel[u]] = ~nb[jk_sel[u]];
                    default: ;
                endcase
            end
            if (u == 0) nb = nb & ~stuck0;
            bank[u] <= nb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input int u, input logic [7:0] v);
        @(negedge clk);
        load[u] = 1'b1;
        load_val[u] = v;
        @(negedge clk);
        load[u] = 1'b0;
    endtask

    task automatic run_word(input int u, input logic [7:0] t,
                            input int exp_done, input int exp_cnt,
                            input logic exp_err, input logic [7:0] exp_bank,
                            input logic [7:0] exp_mask, input logic exp_j,
                            input logic exp_k, input bit poke);
        int cyc;
        int ncmd;
        bit seen;
        logic [7:0] mask;
        @(negedge clk);
        chk("ready_before", in_ready[u], 1);
        in_valid[u] = 1'b1;
        in_target[u] = t;
        @(posedge clk);
        @(negedge clk);
        in_valid[u] = 1'b0;
        cyc = 1;
        ncmd = 0;
        seen = 0;
        mask = '0;
        while (!seen && cyc <= 40) begin
            if (poke && cyc == 2) begin
                in_valid[u] = 1'b1;
                in_target[u] = 8'h7E;
            end
            if (poke && cyc == 4) in_valid[u] = 1'b0;
            if (jk_en[u]) begin
                mask[jk_sel[u]] = 1'b1;
                ncmd++;
                chk("jk_cmd", {J[u], K[u]}, {exp_j, exp_k});
            end
            if (done[u]) begin
                seen = 1;
                chk("done_cycle", cyc, exp_done);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        chk("cmd_count", cmd_count[u], exp_cnt);
        chk("cmds_seen", ncmd, exp_cnt);
        chk("err", err[u], exp_err);
        chk("sel_mask", mask, exp_mask);
        @(negedge clk);
        chk("ready_after", in_ready[u], 1);
        chk("bank", bank[u], exp_bank);
    endtask

    initial begin
        rst = 1'b1;
        stuck0 = '0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u] = 1'b0;
            in_target[u] = '0;
            load[u] = 1'b0;
            load_val[u] = '0;
            bank[u] = '0;
        end
        in_valid[0] = 1'b1;
        in_target[0] = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_ready0", in_ready[0], 1);
        chk("rst_ready1", in_ready[1], 1);
        chk("rst_jk_en", jk_en[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_err", err[0], 0);
        chk("rst_cnt", cmd_count[0], 0);
        in_valid[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready[0], 1);
        chk("post_rst_done", done[0], 0);

        preload(0, 8'h00);
        run_word(0, 8'hA5, 13, 4, 0, 8'hA5, 8'hA5, 1, 0, 0);

        preload(0, 8'h3C);
        run_word(0, 8'h3C, 9, 0, 0, 8'h3C, 8'h00, 1, 0, 0);

        preload(0, 8'h00);
        stuck0 = 8'h08;
        run_word(0, 8'h08, 10, 1, 1, 8'h00, 8'h08, 1, 0, 0);
        @(negedge clk);
        chk("err_held", err[0], 1);
        stuck0 = 8'h00;

        preload(1, 8'h0F);
        run_word(1, 8'hF0, 17, 8, 0, 8'hF0, 8'hFF, 1, 1, 0);

        preload(0, 8'h00);
        run_word(0, 8'h81, 11, 2, 0, 8'h81, 8'h81, 1, 0, 1);
        @(negedge clk);
        chk("no_reaccept", in_ready[0], 1);

        preload(0, 8'h00);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_target[0] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_jk_before", jk_en[0], 1);
        rst = 1'b1;
        #1;
        chk("mid_jk_drop", jk_en[0], 0);
        chk("mid_ready", in_ready[0], 1);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_bank", bank[0], 8'h01);
        chk("mid_cnt", cmd_count[0], 0);
        run_word(0, 8'h03, 10, 1, 0, 8'h03, 8'h02, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
